// File: rtl/conv3x3_ctrl.sv
// ============================================================================
// Module      : conv3x3_ctrl
// Description : Pixel-stream sequencer for a 3x3 convolution window and MAC.
//               Optional stall counter enabled by CONV_CTRL_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv3x3_ctrl #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic       win_shift,
    output logic       mac_in_valid,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_row,
    output logic [7:0] res_col,
    output logic       busy,
    output logic       done
`ifdef CONV_CTRL_STALL_CNT_EN
   ,output logic [15:0] stall_cnt
`endif
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [7:0] c_col_last = 8'(IMG_W - 1);
    localparam logic [7:0] c_row_last = 8'(IMG_H - 1);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [7:0] r_row;
    logic [7:0] r_col;
    logic       r_res_valid;
    logic [7:0] r_res_row;
    logic [7:0] r_res_col;
    logic       w_ready;
    logic       w_accept;
    logic       w_mac;
    logic       w_last_pix;
    logic       w_res_take;
    logic       w_frame_start;

    // A held result that downstream is not taking blocks the next pixel, so
    // the MAC never has to hold two results at once.
    always_comb begin
        w_res_take    = r_res_valid && res_ready;
        w_ready       = rst_n && (r_state == c_st_run) && !(r_res_valid && !res_ready);
        w_accept      = pix_valid && w_ready;
        w_mac         = w_accept && (r_row >= 8'd2) && (r_col >= 8'd2);
        w_last_pix    = w_accept && (r_row == c_row_last) && (r_col == c_col_last);
        w_frame_start = (r_state == c_st_idle) && start;

        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (start) w_state_nxt = c_st_run;
            c_st_run:   if (w_last_pix) w_state_nxt = c_st_drain;
            c_st_drain: if (!r_res_valid || res_ready) w_state_nxt = c_st_done;
            c_st_done:  w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row <= 8'd0;
            r_col <= 8'd0;
        end else if (w_frame_start) begin
            r_row <= 8'd0;
            r_col <= 8'd0;
        end else if (w_accept) begin
            if (r_col == c_col_last) begin
                r_col <= 8'd0;
                r_row <= r_row + 8'd1;
            end else begin
                r_col <= r_col + 8'd1;
            end
        end
    end

    // A new window result takes priority over consumption of the old one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_row   <= 8'd0;
            r_res_col   <= 8'd0;
        end else if (w_mac) begin
            r_res_valid <= 1'b1;
            r_res_row   <= r_row - 8'd2;
            r_res_col   <= r_col - 8'd2;
        end else if (w_res_take) begin
            r_res_valid <= 1'b0;
        end
    end

`ifdef CONV_CTRL_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if (w_frame_start) begin
            r_stall_cnt <= 16'd0;
        end else if ((r_state == c_st_run) && pix_valid && !w_ready &&
                     (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign pix_ready    = w_ready;
    assign win_shift    = w_accept;
    assign mac_in_valid = w_mac;
    assign res_valid    = r_res_valid;
    assign res_row      = r_res_row;
    assign res_col      = r_res_col;
    assign busy         = (r_state == c_st_run) || (r_state == c_st_drain);
    assign done         = (r_state == c_st_done);

endmodule

`default_nettype wire

// File: tb/tb_conv3x3_ctrl.sv
// ============================================================================
// Module      : tb_conv3x3_ctrl
// Description : Self-checking bench for conv3x3_ctrl (4x4 and 3x3 instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv3x3_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, pix_valid, res_ready;
    int   sel;

    logic       a_pix_ready, a_win_shift, a_mac, a_res_valid, a_busy, a_done;
    logic [7:0] a_res_row, a_res_col;
    logic       b_pix_ready, b_win_shift, b_mac, b_res_valid, b_busy, b_done;
    logic [7:0] b_res_row, b_res_col;
`ifdef CONV_CTRL_STALL_CNT_EN
    logic [15:0] a_stall, b_stall;
`endif

    conv3x3_ctrl #(.IMG_W(4), .IMG_H(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start && (sel == 0)),
        .pix_valid(pix_valid), .pix_ready(a_pix_ready), .win_shift(a_win_shift),
        .mac_in_valid(a_mac), .res_valid(a_res_valid), .res_ready(res_ready),
        .res_row(a_res_row), .res_col(a_res_col), .busy(a_busy), .done(a_done)
`ifdef CONV_CTRL_STALL_CNT_EN
       ,.stall_cnt(a_stall)
`endif
    );

    conv3x3_ctrl #(.IMG_W(3), .IMG_H(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start && (sel == 1)),
        .pix_valid(pix_valid), .pix_ready(b_pix_ready), .win_shift(b_win_shift),
        .mac_in_valid(b_mac), .res_valid(b_res_valid), .res_ready(res_ready),
        .res_row(b_res_row), .res_col(b_res_col), .busy(b_busy), .done(b_done)
`ifdef CONV_CTRL_STALL_CNT_EN
       ,.stall_cnt(b_stall)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: frame phase (0 idle, 1 run, 2 drain, 3 done),
    // index of the next pixel to accept, and the single pending result.
    int m_phase, m_k, m_pend, m_pr, m_pc, m_stall;
    int cyc;

    int got_r[$];
    int got_c[$];
    int mac_k[$];
    int done_cnt, done_cyc, last_acc_cyc, first_stall_k, saw_overlap, stall_at_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        got_r.delete(); got_c.delete(); mac_k.delete();
        done_cnt = 0; done_cyc = -1; last_acc_cyc = -1;
        first_stall_k = -1; saw_overlap = 0; stall_at_done = -1;
    endtask

    task automatic tick();
        logic       pr, ws, mv, rv, by, dn;
        logic [7:0] rr, rc;
        logic       e_ready, e_mac, take;
        int         w, h, st;
        @(negedge clk);
        w = (sel == 0) ? 4 : 3;
        h = w;
        st = 0;
        if (sel == 0) begin
            pr = a_pix_ready; ws = a_win_shift; mv = a_mac; rv = a_res_valid;
            by = a_busy; dn = a_done; rr = a_res_row; rc = a_res_col;
`ifdef CONV_CTRL_STALL_CNT_EN
            st = int'(a_stall);
`endif
        end else begin
            pr = b_pix_ready; ws = b_win_shift; mv = b_mac; rv = b_res_valid;
            by = b_busy; dn = b_done; rr = b_res_row; rc = b_res_col;
`ifdef CONV_CTRL_STALL_CNT_EN
            st = int'(b_stall);
`endif
        end

        e_ready = rst_n && (m_phase == 1) && !(m_pend != 0 && !res_ready);
        e_mac   = e_ready && pix_valid && (m_k / w >= 2) && (m_k % w >= 2);
        check("pix_ready", pr, e_ready);
        check("win_shift", ws, e_ready && pix_valid);
        check("mac_in_valid", mv, e_mac);
        check("res_valid", rv, m_pend != 0);
        if (m_pend != 0) begin
            check("res_row", rr, m_pr);
            check("res_col", rc, m_pc);
        end
        check("busy", by, m_phase == 1 || m_phase == 2);
        check("done", dn, m_phase == 3);

        if (rv && res_ready && rst_n) begin
            got_r.push_back(int'(rr));
            got_c.push_back(int'(rc));
        end
        if (mv) mac_k.push_back(m_k);
        if (mv && rv && res_ready) saw_overlap = 1;
        if (dn) begin done_cnt++; done_cyc = cyc; stall_at_done = st; end
        if (ws && m_k == w * h - 1) last_acc_cyc = cyc;
        if (rst_n && m_phase == 1 && !pr && first_stall_k < 0) first_stall_k = m_k;

        if (!rst_n) begin
            m_phase = 0; m_k = 0; m_pend = 0; m_stall = 0;
        end else begin
            take = (m_pend != 0) && res_ready;
            if (m_phase == 1 && pix_valid && !e_ready && m_stall < 65535) m_stall++;
            if (e_mac) begin
                m_pend = 1; m_pr = m_k / w - 2; m_pc = m_k % w - 2;
            end else if (take) begin
                m_pend = 0;
            end
            case (m_phase)
                0: if (start) begin m_phase = 1; m_k = 0; m_stall = 0; end
                1: if (e_ready && pix_valid) begin
                       if (m_k == w * h - 1) m_phase = 2;
                       m_k++;
                   end
                2: if (!take && m_phase == 2 && (m_pend == 0 || res_ready)) m_phase = 3;
                   else if (take) m_phase = 3;
                default: m_phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // mode 0: always valid/ready; 1: random; 2: ready held low 5 cycles once
    // the first result appears; 3: start pulse mid-frame, reset at pixel 7.
    task automatic run_frame(input int mode, input int maxcyc);
        int n, hold;
        clear_logs();
        start = 1'b1; pix_valid = 1'b0; res_ready = 1'b1;
        tick();
        start = 1'b0;
        n = 0; hold = 0;
        while (m_phase != 0 && n < maxcyc) begin
            start = 1'b0;
            case (mode)
                0: begin pix_valid = 1'b1; res_ready = 1'b1; end
                1: begin
                    pix_valid = 1'($urandom_range(0, 1));
                    res_ready = 1'($urandom_range(0, 1));
                end
                2: begin
                    pix_valid = 1'b1;
                    res_ready = !(m_pend != 0 && hold < 5);
                    if (!res_ready) hold++;
                end
                default: begin
                    pix_valid = 1'b1; res_ready = 1'b1;
                    if (m_k == 3) start = 1'b1;
                    if (m_k == 7) rst_n = 1'b0;
                end
            endcase
            tick();
            rst_n = 1'b1;
            n++;
        end
        start = 1'b0; pix_valid = 1'b0;
        check("frame_in_budget", n < maxcyc, 1'b1);
    endtask

    task automatic check_results(input int w, input int h);
        check("result_count", got_r.size(), (w - 2) * (h - 2));
        for (int i = 0; i < got_r.size() && i < (w - 2) * (h - 2); i++) begin
            check("order_row", got_r[i], i / (w - 2));
            check("order_col", got_c[i], i % (w - 2));
        end
        check("done_pulses", done_cnt, 1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; res_ready = 1'b0; sel = 0;
        m_phase = 0; m_k = 0; m_pend = 0; m_pr = 0; m_pc = 0; m_stall = 0; cyc = 0;
        clear_logs();
        @(posedge clk); #1;
        repeat (3) tick();
        rst_n = 1'b1;
        pix_valid = 1'b1;
        repeat (3) tick();

        // Full-throughput 4x4 frame.
        run_frame(0, 200);
        check_results(4, 4);
        check("mac_count", mac_k.size(), 4);
        if (mac_k.size() == 4) begin
            check("mac_pix0", mac_k[0], 10);
            check("mac_pix1", mac_k[1], 11);
            check("mac_pix2", mac_k[2], 14);
            check("mac_pix3", mac_k[3], 15);
        end
        check("done_latency", done_cyc - last_acc_cyc, 2);
        check("overlap_seen", saw_overlap, 1);
        check("no_stall_full_rate", first_stall_k, -1);

        // Downstream backpressure after the first result.
        run_frame(2, 200);
        check_results(4, 4);
        check("first_stall_pixel", first_stall_k, 11);
`ifdef CONV_CTRL_STALL_CNT_EN
        check("stall_cnt_at_done", stall_at_done, 5);
        repeat (2) tick();
        check("stall_cnt_holds", a_stall, 5);
`endif

        // Start ignored mid-frame, reset at pixel 7, then a clean frame.
        run_frame(3, 200);
        repeat (3) tick();
        check("abort_no_done", done_cnt, 0);
        check("abort_no_result", got_r.size(), 0);
        run_frame(1, 1000);
        check_results(4, 4);
        run_frame(1, 1000);
        check_results(4, 4);

        // Minimum 3x3 image.
        sel = 1;
        repeat (2) tick();
        run_frame(0, 200);
        check_results(3, 3);
        check("mac3_count", mac_k.size(), 1);
        if (mac_k.size() == 1) check("mac3_pix", mac_k[0], 8);
        run_frame(1, 1000);
        check_results(3, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
